// File: rtl/music_pkg.sv
// Shared definitions for the note-table music sequencer.
// Contents: FSM state enum, note-table word layout, end marker,
// default timing parameters and a helper that turns a duration code
// into a note length in milliseconds.
package music_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_PLAY  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_e;

  localparam logic [15:0] END_MARKER      = 16'hFFFF;
  localparam int          DUR_MSB         = 15;
  localparam int          DUR_LSB         = 12;
  localparam int          HALF_W          = 12;
  localparam int          DEF_GAP_MS      = 20;
  localparam int          DEF_DUR_UNIT_MS = 50;

  // Note length in ms: (code + 1) * unit, kept to 10 bits (max 16*50 = 800).
  function automatic logic [9:0] note_ms(input logic [3:0] code, input int unit_ms);
    return 10'((32'(code) + 32'd1) * 32'(unit_ms));
  endfunction

endpackage

// File: rtl/music_sequencer_if.sv
// Note-table read bus between the sequencer and the table storage.
// note_addr : table read address (driven by the sequencer)
// note_data : table word, combinational read of note_addr
// Modports: master = sequencer side, slave = table side.
interface music_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] note_addr;
  logic [15:0]       note_data;

  modport master (output note_addr, input note_data);
  modport slave  (input note_addr, output note_data);
endinterface

// File: rtl/music_sequencer_ms_prescaler.sv
// Millisecond prescaler: counts 0..max(ticks_per_milli,1)-1 and emits a
// one-cycle ms_tick on wrap. If ticks_per_milli shrinks below the current
// count, the counter wraps on the very next cycle.
// Ports: clk, rst_n (async active-low), clear (sync zero), hold (freeze),
//        ticks_per_milli (clk cycles per ms, 0 treated as 1) -> ms_tick.
module ms_prescaler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        hold,
  input  logic [15:0] ticks_per_milli,
  output logic        ms_tick
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] last_s;

  always_comb begin
    cnt_d   = cnt_q;
    ms_tick = 1'b0;
    last_s  = (ticks_per_milli == 16'd0) ? 16'd0 : (ticks_per_milli - 16'd1);
    if (clear) begin
      cnt_d = 16'd0;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q >= last_s) begin
      // ">=" rather than "==" so a shrinking limit wraps immediately
      cnt_d   = 16'd0;
      ms_tick = 1'b1;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/music_sequencer.sv
// Music sequencer: walks a note table, enables the tone generator for
// each note's duration, inserts a fixed silent gap, and finishes on an end
// marker / end of table or loops back to entry 0.
// Ports: clk, rst_n (async active-low); start, stop, loop_en, pause,
//        ticks_per_milli (control); tbl (note-table bus, master modport);
//        tone_half_period, tone_en, led, busy, done (registered outputs).
// Build option: define MUSIC_SEQ_PAUSE_EN to build the pause feature;
// without it, pause is ignored.
module music_sequencer
  import music_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int GAP_MS      = DEF_GAP_MS,
  parameter int DUR_UNIT_MS = DEF_DUR_UNIT_MS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                pause,
  input  logic [15:0]         ticks_per_milli,
  music_sequencer_if.master   tbl,
  output logic [HALF_W-1:0]   tone_half_period,
  output logic                tone_en,
  output logic [7:0]          led,
  output logic                busy,
  output logic                done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [9:0]        GAP_LAST  = 10'(GAP_MS - 1);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] note_addr_q, note_addr_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              tone_en_q, tone_en_d;
  logic [7:0]        led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [9:0]        dur_q, dur_d;
  logic [9:0]        ms_cnt_q, ms_cnt_d;
  logic              ms_tick_s;
  logic              timing_s;
  logic              pause_s;

  assign timing_s = (state_q == ST_PLAY) || (state_q == ST_GAP);

`ifdef MUSIC_SEQ_PAUSE_EN
  assign pause_s = pause && timing_s;
`else
  logic unused_s;
  assign unused_s = ^{1'b0, pause};
  assign pause_s  = 1'b0;
`endif

  // Prescaler is held at zero outside PLAY/GAP so every note and gap starts fresh
  ms_prescaler u_prescaler (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (!timing_s),
    .hold            (pause_s),
    .ticks_per_milli (ticks_per_milli),
    .ms_tick         (ms_tick_s)
  );

  always_comb begin
    state_d     = state_q;
    note_addr_d = note_addr_q;
    half_d      = half_q;
    tone_en_d   = tone_en_q;
    led_d       = led_q;
    dur_d       = dur_q;
    ms_cnt_d    = ms_cnt_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_FETCH;
          note_addr_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (tbl.note_data == END_MARKER) begin
          if (loop_en) begin
            note_addr_d = '0;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          state_d   = ST_PLAY;
          half_d    = tbl.note_data[HALF_W-1:0];
          tone_en_d = (tbl.note_data[HALF_W-1:0] != 12'd0);
          led_d     = 8'd1 << note_addr_q[2:0];
          dur_d     = note_ms(tbl.note_data[DUR_MSB:DUR_LSB], DUR_UNIT_MS);
          ms_cnt_d  = 10'd0;
        end
      end
      ST_PLAY: begin
        // A rest (half == 0) keeps the tone off; pause masks it temporarily
        tone_en_d = (half_q != 12'd0) && !pause_s;
        if (ms_tick_s) begin
          if (ms_cnt_q == dur_q - 10'd1) begin
            state_d   = ST_GAP;
            tone_en_d = 1'b0;
            led_d     = 8'd0;
            ms_cnt_d  = 10'd0;
          end else begin
            ms_cnt_d = ms_cnt_q + 10'd1;
          end
        end else begin
          ms_cnt_d = ms_cnt_q;
        end
      end
      ST_GAP: begin
        if (ms_tick_s) begin
          if (ms_cnt_q == GAP_LAST) begin
            ms_cnt_d = 10'd0;
            if (note_addr_q != LAST_ADDR) begin
              note_addr_d = note_addr_q + 1'b1;
              state_d     = ST_FETCH;
            end else if (loop_en) begin
              note_addr_d = '0;
              state_d     = ST_FETCH;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            ms_cnt_d = ms_cnt_q + 10'd1;
          end
        end else begin
          ms_cnt_d = ms_cnt_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        tone_en_d = 1'b0;
        led_d     = 8'd0;
      end
    endcase

    // Abort overrides everything, including a completion in the same cycle
    if (stop && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      tone_en_d = 1'b0;
      led_d     = 8'd0;
      ms_cnt_d  = 10'd0;
      done_d    = 1'b0;
    end else begin
      state_d = state_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      note_addr_q <= '0;
      half_q      <= 12'd0;
      tone_en_q   <= 1'b0;
      led_q       <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dur_q       <= 10'd0;
      ms_cnt_q    <= 10'd0;
    end else begin
      state_q     <= state_d;
      note_addr_q <= note_addr_d;
      half_q      <= half_d;
      tone_en_q   <= tone_en_d;
      led_q       <= led_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dur_q       <= dur_d;
      ms_cnt_q    <= ms_cnt_d;
    end
  end

  assign tbl.note_addr     = note_addr_q;
  assign tone_half_period  = half_q;
  assign tone_en           = tone_en_q;
  assign led               = led_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule
